// File: rtl/window_addr_gen.sv
// K x K sliding-window read-address generator plus dense write-address generator.
// Optional source row stride port: WINDOW_ADDR_GEN_PITCH_EN.
module window_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_init_raddr,
    input  logic [ADDR_W-1:0] i_init_waddr,
    input  logic [DIM_W-1:0]  i_img_width,
    input  logic [DIM_W-1:0]  i_img_height,
`ifdef WINDOW_ADDR_GEN_PITCH_EN
    input  logic [DIM_W-1:0]  i_row_pitch,
`endif
    input  logic              i_rready,
    input  logic              i_wready,
    output logic [ADDR_W-1:0] o_raddr,
    output logic              o_rvalid,
    output logic              o_rlast,
    output logic [ADDR_W-1:0] o_waddr,
    output logic              o_wvalid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam logic [3:0]       KM1 = 4'(K - 1);
    localparam logic [DIM_W-1:0] KD  = DIM_W'(K);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;

    logic [3:0]        kx, ky;
    logic [DIM_W-1:0]  col, row, wcol, wrow, col_lim, row_lim;
    logic [ADDR_W-1:0] pitch, row_base, win_base, line_ptr;
    logic [DIM_W-1:0]  start_pitch;
    logic              dims_ok;
    logic              r_acc, w_acc, win_end, r_fin, w_fin;
    logic [ADDR_W-1:0] win_next, row_next;

    always_comb begin
        start_pitch = i_img_width;
        dims_ok     = (i_img_width >= KD) && (i_img_height >= KD);
`ifdef WINDOW_ADDR_GEN_PITCH_EN
        start_pitch = i_row_pitch;
        dims_ok     = dims_ok && (i_row_pitch >= i_img_width);
`endif
    end

    assign r_acc    = o_rvalid & i_rready;
    assign w_acc    = o_wvalid & i_wready;
    assign win_end  = (kx == KM1) && (ky == KM1);
    // A stream is finished once its valid has dropped or its final accept happens now.
    assign r_fin    = !o_rvalid || (r_acc && win_end && col == col_lim && row == row_lim);
    assign w_fin    = !o_wvalid || (w_acc && wcol == col_lim && wrow == row_lim);
    assign win_next = win_base + ADDR_W'(1);
    assign row_next = row_base + pitch;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            kx       <= '0;
            ky       <= '0;
            col      <= '0;
            row      <= '0;
            wcol     <= '0;
            wrow     <= '0;
            col_lim  <= '0;
            row_lim  <= '0;
            pitch    <= '0;
            row_base <= '0;
            win_base <= '0;
            line_ptr <= '0;
            o_raddr  <= '0;
            o_rvalid <= 1'b0;
            o_rlast  <= 1'b0;
            o_waddr  <= '0;
            o_wvalid <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        if (dims_ok) begin
                            state    <= RUN;
                            o_err    <= 1'b0;
                            col_lim  <= i_img_width - KD;
                            row_lim  <= i_img_height - KD;
                            pitch    <= ADDR_W'(start_pitch);
                            kx       <= '0;
                            ky       <= '0;
                            col      <= '0;
                            row      <= '0;
                            wcol     <= '0;
                            wrow     <= '0;
                            row_base <= i_init_raddr;
                            win_base <= i_init_raddr;
                            line_ptr <= i_init_raddr;
                            o_raddr  <= i_init_raddr;
                            o_waddr  <= i_init_waddr;
                            o_rvalid <= 1'b1;
                            o_wvalid <= 1'b1;
                            o_rlast  <= (KM1 == 4'd0);
                            o_busy   <= 1'b1;
                        end else begin
                            state  <= FIN;
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        state    <= IDLE;
                        o_rvalid <= 1'b0;
                        o_wvalid <= 1'b0;
                        o_rlast  <= 1'b0;
                        o_busy   <= 1'b0;
                    end else begin
                        if (r_acc) begin
                            if (kx != KM1) begin
                                kx      <= kx + 4'd1;
                                o_raddr <= line_ptr + ADDR_W'(kx) + ADDR_W'(1);
                                o_rlast <= (kx + 4'd1 == KM1) && (ky == KM1);
                            end else if (ky != KM1) begin
                                kx       <= '0;
                                ky       <= ky + 4'd1;
                                line_ptr <= line_ptr + pitch;
                                o_raddr  <= line_ptr + pitch;
                                o_rlast  <= 1'b0;
                            end else begin
                                kx      <= '0;
                                ky      <= '0;
                                o_rlast <= (KM1 == 4'd0);
                                if (col != col_lim) begin
                                    col      <= col + 1'b1;
                                    win_base <= win_next;
                                    line_ptr <= win_next;
                                    o_raddr  <= win_next;
                                end else if (row != row_lim) begin
                                    col      <= '0;
                                    row      <= row + 1'b1;
                                    row_base <= row_next;
                                    win_base <= row_next;
                                    line_ptr <= row_next;
                                    o_raddr  <= row_next;
                                end else begin
                                    o_rvalid <= 1'b0;
                                    o_rlast  <= 1'b0;
                                end
                            end
                        end
                        if (w_acc) begin
                            o_waddr <= o_waddr + ADDR_W'(1);
                            if (wcol != col_lim) begin
                                wcol <= wcol + 1'b1;
                            end else if (wrow != row_lim) begin
                                wcol <= '0;
                                wrow <= wrow + 1'b1;
                            end else begin
                                o_wvalid <= 1'b0;
                            end
                        end
                        if (r_fin && w_fin) begin
                            state  <= FIN;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: scoreboard queues of expected read/write addresses.
module tb_window_addr_gen;
    localparam int ADDR_W = 32;
    localparam int DIM_W  = 16;
    localparam int K      = 3;

    logic              clk = 1'b0;
    logic              n_rst, i_start, i_abort, i_rready, i_wready;
    logic [ADDR_W-1:0] i_init_raddr, i_init_waddr;
    logic [DIM_W-1:0]  i_img_width, i_img_height, i_row_pitch;
    logic [ADDR_W-1:0] o_raddr, o_waddr;
    logic              o_rvalid, o_rlast, o_wvalid, o_busy, o_done, o_err;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    window_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .K(K)) dut (
        .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_abort(i_abort),
        .i_init_raddr(i_init_raddr), .i_init_waddr(i_init_waddr),
        .i_img_width(i_img_width), .i_img_height(i_img_height),
`ifdef WINDOW_ADDR_GEN_PITCH_EN
        .i_row_pitch(i_row_pitch),
`endif
        .i_rready(i_rready), .i_wready(i_wready),
        .o_raddr(o_raddr), .o_rvalid(o_rvalid), .o_rlast(o_rlast),
        .o_waddr(o_waddr), .o_wvalid(o_wvalid), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_cfg(input int w, input int h, input int p, input logic [31:0] rb, input logic [31:0] wb);
        i_img_width  = DIM_W'(w);
        i_img_height = DIM_W'(h);
        i_row_pitch  = DIM_W'(p);
        i_init_raddr = rb;
        i_init_waddr = wb;
    endtask

    // Starts a frame and follows it to o_done, comparing every accepted address.
    task automatic run_frame(input int w, input int h, input int p, input logic [31:0] rb,
                             input logic [31:0] wb, input bit rrand, input int wstall);
        logic [31:0] rq[$];
        bit          lq[$];
        logic [31:0] wq[$];
        logic [31:0] prev_raddr, e;
        bit          le, done_seen, prev_rstall;
        int          cyc, last_acc;
        for (int r = 0; r <= h - K; r++)
            for (int c = 0; c <= w - K; c++)
                for (int y = 0; y < K; y++)
                    for (int x = 0; x < K; x++) begin
                        rq.push_back(rb + 32'((r + y) * p + c + x));
                        lq.push_back(x == K - 1 && y == K - 1);
                    end
        for (int n = 0; n < (w - K + 1) * (h - K + 1); n++) wq.push_back(wb + 32'(n));

        set_cfg(w, h, p, rb, wb);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start  = 1'b0;
        i_rready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
        i_wready = (wstall > 0) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("first_raddr", o_raddr, rb);
        chk("first_waddr", o_waddr, wb);
        chk("start_busy", {o_busy, o_rvalid, o_wvalid, o_err}, 4'b1110);

        cyc = 0; last_acc = -10; done_seen = 0; prev_rstall = 0; prev_raddr = '0;
        while (!done_seen && cyc < 600) begin
            if (o_done) begin
                done_seen = 1;
                chk("done_timing", cyc, last_acc + 1);
                chk("reads_left", rq.size(), 0);
                chk("writes_left", wq.size(), 0);
                chk("done_busy", o_busy, 1'b0);
            end else begin
                if (prev_rstall) chk("raddr_stable", {o_rvalid, o_raddr}, {1'b1, prev_raddr});
                if (o_rvalid && i_rready) begin
                    if (rq.size() == 0) chk("extra_read", 1, 0);
                    else begin
                        e = rq.pop_front(); le = lq.pop_front();
                        chk("raddr", o_raddr, e);
                        chk("rlast", o_rlast, le);
                        last_acc = cyc;
                    end
                end
                prev_rstall = o_rvalid && !i_rready;
                prev_raddr  = o_raddr;
                if (o_wvalid && i_wready) begin
                    if (wq.size() == 0) chk("extra_write", 1, 0);
                    else begin
                        e = wq.pop_front();
                        chk("waddr", o_waddr, e);
                        last_acc = cyc;
                    end
                end
                @(posedge clk); #1;
                cyc++;
                i_rready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
                i_wready = (cyc < wstall) ? 1'b0 : 1'b1;
                @(negedge clk);
            end
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        else begin
            @(negedge clk);
            chk("done_one_cycle", {o_done, o_busy}, 2'b00);
        end
    endtask

    initial begin
        bit seen;
        int nacc;
        n_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_rready = 1'b1; i_wready = 1'b1;
        set_cfg(5, 4, 5, 32'h100, 32'h200);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {o_raddr, o_waddr, o_rvalid, o_rlast, o_wvalid, o_busy, o_done, o_err}, '0);

        // Free-running frame, then the same frame under read/write backpressure.
        run_frame(5, 4, 5, 32'h100, 32'h200, 1'b0, 0);
        run_frame(5, 4, 5, 32'h100, 32'h200, 1'b1, 40);

        // Illegal width: immediate done with error, no addresses.
        @(posedge clk); #1;
        set_cfg(2, 4, 2, 32'h100, 32'h200);
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(negedge clk);
        chk("illegal_done", {o_done, o_err, o_rvalid, o_wvalid, o_busy}, 5'b11000);
        @(negedge clk);
        chk("illegal_after", {o_done, o_err, o_busy}, 3'b010);
        run_frame(5, 4, 5, 32'h100, 32'h200, 1'b0, 0);
        chk("err_cleared", o_err, 1'b0);

        // Abort after ten reads.
        @(posedge clk); #1;
        set_cfg(5, 4, 5, 32'h100, 32'h200);
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_rvalid && i_rready) nacc++;
            @(posedge clk); #1;
        end
        chk("abort_reads", nacc, 10);
        i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {o_busy, o_rvalid, o_wvalid, o_done}, 4'b0000);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        chk("abort_no_done", seen, 1'b0);
        run_frame(5, 4, 5, 32'h100, 32'h200, 1'b0, 0);

        // Reset mid-frame.
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (7) @(posedge clk);
        #1 n_rst = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {o_raddr, o_waddr, o_rvalid, o_rlast, o_wvalid, o_busy, o_done, o_err}, '0);
        run_frame(5, 4, 5, 32'h100, 32'h200, 1'b0, 0);

`ifdef WINDOW_ADDR_GEN_PITCH_EN
        run_frame(5, 4, 8, 32'h0, 32'h40, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
Parametrised K×K sliding-window address generator for the edge-detection datapath. It replaces the fixed 3×3, fixed-width read/write address counter.
- Read stream: for every valid window position of a W×H image, emits the K*K source addresses in row-major order.
- Write stream: emits one dense, linear destination address per output pixel.
- Both streams use valid/ready handshakes; a single start/done pair brackets each frame.

Parameters:
- ADDR_W, 32, width of all addresses.
- DIM_W, 16, width of the image width/height inputs.
- K, 3, window edge length (legal range 1..15).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; synchronous, active-low.
- i_start  in  1  frame start pulse; sampled only in IDLE.
- i_abort  in  1  cancel the current frame.
- i_init_raddr  in  ADDR_W  source base address (top-left pixel).
- i_init_waddr  in  ADDR_W  destination base address.
- i_img_width  in  DIM_W  image width W.
- i_img_height  in  DIM_W  image height H.
- i_rready  in  1  read-address consumer ready.
- i_wready  in  1  write-address consumer ready.
- o_raddr  out  ADDR_W  current read address.
- o_rvalid  out  1  o_raddr valid.
- o_rlast  out  1  o_raddr is the last (K*K-th) address of its window.
- o_waddr  out  ADDR_W  current write address.
- o_wvalid  out  1  o_waddr valid.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle frame-complete pulse.
- o_err  out  1  illegal dimensions for the last start; sticky.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including o_raddr and o_waddr.
  - All internal counters and pointers clear.
  - Reset overrides i_start and i_abort. A reset in mid-frame discards the frame with no o_done.
- State machine: IDLE, RUN, FIN.
- IDLE → RUN on i_start when W>=K and H>=K.
  - W, H, i_init_raddr and i_init_waddr are latched at that edge.
  - Next cycle: o_raddr=i_init_raddr, o_waddr=i_init_waddr, o_rvalid=o_wvalid=o_busy=1. Start-to-valid latency is 1 cycle.
- IDLE with i_start and (W<K or H<K):
  - Go to FIN. o_err=1; no addresses are issued.
  - o_err clears on the next legal start.
- Read stream:
  - Registers: kx, ky (0..K-1), col (0..W-K), row (0..H-K), row_base, win_base, line_ptr.
  - o_raddr = line_ptr + kx, registered.
  - The stream advances only on o_rvalid & i_rready; o_raddr is held stable while stalled.
  - On each accept, in priority order:
    - kx<K-1: kx+1.
    - kx=K-1, ky<K-1: kx=0, ky+1, line_ptr += W.
    - Window complete (o_rlast was 1):
      - col<W-K: col+1, win_base+1, line_ptr=win_base+1.
      - else row<H-K: col=0, row+1, row_base += W, win_base=line_ptr=row_base+W.
      - else: the read stream is finished; o_rvalid drops next cycle.
  - No multipliers: all address arithmetic is additions of ADDR_W width. W is zero-extended; wrap modulo 2^ADDR_W.
  - o_rlast = (kx==K-1 && ky==K-1) && o_rvalid.
- Write stream:
  - Independent counters wcol and wrow.
  - On o_wvalid & i_wready: o_waddr+1.
  - After the accept with wcol=W-K and wrow=H-K, o_wvalid drops.
  - Total writes = (W-K+1)*(H-K+1).
- The read and write streams may run at any relative rate; neither blocks the other.
- RUN → FIN in the cycle after both streams have finished. Simultaneous final accepts on both streams are legal.
- FIN:
  - o_done=1 for exactly one cycle; o_busy=0; then go to IDLE.
- i_abort in RUN: next cycle the state is IDLE; o_rvalid, o_wvalid and o_busy drop; no o_done.
- i_start outside IDLE is ignored. i_abort in IDLE or FIN is ignored.
- K=1 degenerates to a pixel copy: o_rlast=1 on every read.

Optional Feature:
- Macro: WINDOW_ADDR_GEN_PITCH_EN.
- When defined:
  - Adds port i_row_pitch (in, DIM_W), latched at start; it replaces W in every line_ptr/row_base increment (source buffer row stride).
  - Also adds an error condition: pitch < W raises o_err like illegal dimensions.
- When undefined: no such port; the pitch equals W.

Test Plan:
- W=5, H=4, K=3, raddr=0x100, waddr=0x200, ready tied 1:
  - First nine reads are 100,101,102,105,106,107,10A,10B,10C; o_rlast on 10C.
  - Window 2 starts at 101; window 4 starts at 105.
  - Last read is 113.
  - 54 reads, writes 200..205.
  - o_done exactly one cycle after the final accept.
- Same config, i_rready toggling randomly and i_wready held 0 for the first 40 cycles: the address sequences are identical to the previous test, o_raddr is stable while stalled, and o_done occurs only after write 205.
- i_start with W=2, H=4, K=3: no valids, o_err=1, o_done pulse 1 cycle after start; a legal start then clears o_err.
- i_abort after 10 reads: o_busy and valids are 0 the next cycle, and no o_done. A restart begins again at i_init_raddr.
- n_rst=0 mid-frame: all outputs are 0 after that edge, and the next start behaves as in the first test.
- WINDOW_ADDR_GEN_PITCH_EN with W=5, pitch=8, K=3, raddr=0: the first window reads 0,1,2,8,9,10,16,17,18.
